// File: rtl/pim_mac_seq.sv
`default_nettype none
// ============================================================================
// Module   : pim_mac_seq
// Purpose  : Bit-serial MAC job sequencer in front of the PIM CFU array.
//            Loads weight rows, issues MAC steps, returns the last response.
// Revision : 1.0 - initial release
// ============================================================================
module pim_mac_seq #(
    parameter int DWIDTH    = 32,
    parameter int FWIDTH    = 10,
    parameter int MAX_ROWS  = 256,
    parameter int ADDR_BASE = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              job_valid,
    output logic              job_ready,
    input  logic [8:0]        job_rows,
    input  logic [5:0]        job_steps,
    input  logic              row_valid,
    output logic              row_ready,
    input  logic [DWIDTH-1:0] row_data,
    output logic              pim_cmd_valid,
    input  logic              pim_cmd_ready,
    output logic [FWIDTH-1:0] pim_function_id,
    output logic [DWIDTH-1:0] pim_inputs_0,
    output logic [DWIDTH-1:0] pim_inputs_1,
    input  logic              pim_rsp_valid,
    output logic              pim_rsp_ready,
    input  logic [DWIDTH-1:0] pim_rsp_data,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DWIDTH-1:0] res_data,
    output logic              busy
);

    localparam logic [8:0]        c_MAX_ROWS  = 9'(MAX_ROWS);
    localparam logic [5:0]        c_MAX_STEPS = 6'd32;
    localparam logic [7:0]        c_ADDR_BASE = 8'(ADDR_BASE);
    localparam logic [FWIDTH-1:0] c_FID_WRITE = FWIDTH'(1);
    localparam logic [FWIDTH-1:0] c_FID_MAC   = FWIDTH'(2);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_LOAD_GET   = 3'd1,
        S_LOAD_ISSUE = 3'd2,
        S_LOAD_WAIT  = 3'd3,
        S_MAC_ISSUE  = 3'd4,
        S_MAC_WAIT   = 3'd5,
        S_DONE       = 3'd6
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [8:0]        r_rows;
    logic [5:0]        r_steps;
    logic [8:0]        r_row_idx;
    logic [5:0]        r_step_idx;
    logic [DWIDTH-1:0] r_row_data;
    logic [DWIDTH-1:0] r_result;

    logic [8:0]        w_rows_sat;
    logic [5:0]        w_steps_sat;
    logic [7:0]        w_addr;
    logic              w_row_last;
    logic              w_step_last;

    assign w_rows_sat  = (job_rows > c_MAX_ROWS) ? c_MAX_ROWS : job_rows;
    assign w_steps_sat = (job_steps > c_MAX_STEPS) ? c_MAX_STEPS : job_steps;
    assign w_addr      = c_ADDR_BASE + r_row_idx[7:0];
    assign w_row_last  = ((r_row_idx + 9'd1) == r_rows);
    assign w_step_last = ((r_step_idx + 6'd1) == r_steps);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Outputs decode straight from state so an async reset clears them at once
    always_comb begin
        w_next          = r_state;
        job_ready       = 1'b0;
        row_ready       = 1'b0;
        pim_cmd_valid   = 1'b0;
        pim_function_id = '0;
        pim_inputs_0    = '0;
        pim_inputs_1    = '0;
        pim_rsp_ready   = 1'b0;
        res_valid       = 1'b0;
        res_data        = '0;
        busy            = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                job_ready = 1'b1;
                if (job_valid) begin
                    if (w_rows_sat != 9'd0)       w_next = S_LOAD_GET;
                    else if (w_steps_sat != 6'd0) w_next = S_MAC_ISSUE;
                    else                          w_next = S_DONE;
                end
            end
            S_LOAD_GET: begin
                row_ready = 1'b1;
                if (row_valid) w_next = S_LOAD_ISSUE;
            end
            S_LOAD_ISSUE: begin
                pim_cmd_valid   = 1'b1;
                pim_function_id = c_FID_WRITE;
                pim_inputs_0    = r_row_data;
                pim_inputs_1    = {{(DWIDTH-8){1'b0}}, w_addr};
                if (pim_cmd_ready) w_next = S_LOAD_WAIT;
            end
            S_LOAD_WAIT: begin
                pim_rsp_ready = 1'b1;
                if (pim_rsp_valid) begin
                    if (!w_row_last)           w_next = S_LOAD_GET;
                    else if (r_steps != 6'd0)  w_next = S_MAC_ISSUE;
                    else                       w_next = S_DONE;
                end
            end
            S_MAC_ISSUE: begin
                pim_cmd_valid   = 1'b1;
                pim_function_id = c_FID_MAC;
                if (pim_cmd_ready) w_next = S_MAC_WAIT;
            end
            S_MAC_WAIT: begin
                pim_rsp_ready = 1'b1;
                if (pim_rsp_valid) w_next = w_step_last ? S_DONE : S_MAC_ISSUE;
            end
            S_DONE: begin
                res_valid = 1'b1;
                res_data  = r_result;
                if (res_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rows     <= '0;
            r_steps    <= '0;
            r_row_idx  <= '0;
            r_step_idx <= '0;
            r_row_data <= '0;
            r_result   <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (job_valid) begin
                    r_rows     <= w_rows_sat;
                    r_steps    <= w_steps_sat;
                    r_row_idx  <= '0;
                    r_step_idx <= '0;
                    r_result   <= '0;
                end
                S_LOAD_GET:  if (row_valid)     r_row_data <= row_data;
                S_LOAD_WAIT: if (pim_rsp_valid) r_row_idx  <= r_row_idx + 9'd1;
                S_MAC_WAIT: if (pim_rsp_valid) begin
                    r_result   <= pim_rsp_data;
                    r_step_idx <= r_step_idx + 6'd1;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pim_mac_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_pim_mac_seq
// Purpose  : Self-checking bench for pim_mac_seq with a PIM responder model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pim_mac_seq;

    localparam int DW    = 32;
    localparam int FW    = 10;
    localparam int ABASE = 0;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          job_valid = 1'b0;
    logic          job_ready;
    logic [8:0]    job_rows = '0;
    logic [5:0]    job_steps = '0;
    logic          row_valid = 1'b0;
    logic          row_ready;
    logic [DW-1:0] row_data = '0;
    logic          pim_cmd_valid;
    logic          pim_cmd_ready = 1'b0;
    logic [FW-1:0] pim_function_id;
    logic [DW-1:0] pim_inputs_0;
    logic [DW-1:0] pim_inputs_1;
    logic          pim_rsp_valid = 1'b0;
    logic          pim_rsp_ready;
    logic [DW-1:0] pim_rsp_data = '0;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic [DW-1:0] res_data;
    logic          busy;

    pim_mac_seq #(.DWIDTH(DW), .FWIDTH(FW), .MAX_ROWS(256), .ADDR_BASE(ABASE)) dut (
        .clk(clk), .reset(reset),
        .job_valid(job_valid), .job_ready(job_ready), .job_rows(job_rows), .job_steps(job_steps),
        .row_valid(row_valid), .row_ready(row_ready), .row_data(row_data),
        .pim_cmd_valid(pim_cmd_valid), .pim_cmd_ready(pim_cmd_ready),
        .pim_function_id(pim_function_id), .pim_inputs_0(pim_inputs_0), .pim_inputs_1(pim_inputs_1),
        .pim_rsp_valid(pim_rsp_valid), .pim_rsp_ready(pim_rsp_ready), .pim_rsp_data(pim_rsp_data),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [FW-1:0] fid;
        logic [DW-1:0] in0;
        logic [DW-1:0] in1;
    } cmd_t;

    int            n_tests = 0;
    int            n_fail  = 0;
    cmd_t          cmd_log[$];
    logic [DW-1:0] row_q[$];
    logic [DW-1:0] mac_rsp_q[$];
    logic [DW-1:0] exp_rows[$];
    logic [DW-1:0] exp_macs[$];
    int            cmd_stall = 0;
    int            rsp_delay = 0;
    bit            row_gaps  = 0;
    int            stall_cycles_seen = 0;

    // PIM responder: decides handshakes at negedge so they land on the next posedge
    bit   cmd_fire_pend = 0, rsp_fire_pend = 0, owe = 0, owe_mac = 0, prev_stalled = 0;
    int   rsp_wait = 0, stall_ctr = 0;
    cmd_t held;
    always @(negedge clk) begin
        if (reset) begin
            pim_cmd_ready = 1'b0; pim_rsp_valid = 1'b0; pim_rsp_data = '0;
            cmd_fire_pend = 0; rsp_fire_pend = 0; owe = 0; stall_ctr = 0; prev_stalled = 0;
        end else begin
            if (rsp_fire_pend) begin
                pim_rsp_valid = 1'b0; pim_rsp_data = '0; rsp_fire_pend = 0;
            end
            if (cmd_fire_pend) begin
                cmd_fire_pend = 0; owe = 1; rsp_wait = rsp_delay;
            end
            if (owe) begin
                if (rsp_wait == 0) begin
                    pim_rsp_valid = 1'b1; owe = 0;
                    if (owe_mac && mac_rsp_q.size() > 0) pim_rsp_data = mac_rsp_q.pop_front();
                    else                                 pim_rsp_data = $urandom;
                end else begin
                    rsp_wait--;
                end
            end
            if (prev_stalled) begin
                n_tests++;
                if (!pim_cmd_valid || pim_function_id !== held.fid ||
                    pim_inputs_0 !== held.in0 || pim_inputs_1 !== held.in1) begin
                    n_fail++;
                    $display("FAIL cmd_stable: got v=%0b fid=%0h in0=%0h in1=%0h, want v=1 fid=%0h in0=%0h in1=%0h",
                             pim_cmd_valid, pim_function_id, pim_inputs_0, pim_inputs_1,
                             held.fid, held.in0, held.in1);
                end
            end
            if (pim_cmd_valid && stall_ctr < cmd_stall) begin
                pim_cmd_ready = 1'b0; stall_ctr++; stall_cycles_seen++; prev_stalled = 1;
                held.fid = pim_function_id; held.in0 = pim_inputs_0; held.in1 = pim_inputs_1;
            end else begin
                pim_cmd_ready = pim_cmd_valid; prev_stalled = 0;
            end
            if (pim_cmd_valid && pim_cmd_ready) begin
                cmd_t c;
                c.fid = pim_function_id; c.in0 = pim_inputs_0; c.in1 = pim_inputs_1;
                cmd_log.push_back(c);
                cmd_fire_pend = 1; owe_mac = (pim_function_id == FW'(2)); stall_ctr = 0;
            end
            if (pim_rsp_valid && pim_rsp_ready) rsp_fire_pend = 1;
            if (pim_cmd_valid) begin
                n_tests++;
                if (pim_rsp_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rsp_ready_in_issue: got %0b want 0", pim_rsp_ready);
                end
            end
        end
    end

    // Row source: pops a word once its handshake has landed
    bit row_fire_pend = 0;
    always @(negedge clk) begin
        if (reset) begin
            row_valid = 1'b0; row_data = '0; row_fire_pend = 0;
        end else begin
            if (row_fire_pend) begin
                row_q.delete(0); row_fire_pend = 0;
            end
            row_valid = (row_q.size() > 0) && (!row_gaps || $urandom_range(0, 2) != 0);
            row_data  = row_valid ? row_q[0] : '0;
            if (row_valid && row_ready) row_fire_pend = 1;
        end
    end

    task automatic send_job(input int rows, input int steps);
        int k = 0;
        job_rows = 9'(rows); job_steps = 6'(steps); job_valid = 1'b1;
        while (!job_ready && k < 100) begin @(negedge clk); k++; end
        n_tests++;
        if (job_ready !== 1'b1) begin
            n_fail++; $display("FAIL job_accept: job_ready=%0b want 1", job_ready);
        end
        @(negedge clk);
        job_valid = 1'b0;
    endtask

    task automatic wait_result(input int budget, output int cycles,
                               output logic [DW-1:0] data, output bit busy_dropped);
        cycles = 0; busy_dropped = 0;
        while (!res_valid && cycles < budget) begin
            if (!busy) busy_dropped = 1;
            @(negedge clk); cycles++;
        end
        n_tests++;
        if (res_valid !== 1'b1) begin
            n_fail++; $display("FAIL res_timeout: res_valid=%0b after %0d cycles want 1", res_valid, cycles);
        end
        data = res_data;
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    // Reference: R writes of the supplied rows at ABASE+i, then S MACs; result is the S-th MAC response
    task automatic run_job(input int rows, input int steps, input string tag,
                           output int cycles, output bit busy_dropped);
        int            r_exp = (rows > 256) ? 256 : rows;
        int            s_exp = (steps > 32) ? 32 : steps;
        logic [DW-1:0] got;
        logic [DW-1:0] want;
        cmd_log.delete();
        row_q = exp_rows;
        mac_rsp_q = exp_macs;
        send_job(rows, steps);
        wait_result(5000, cycles, got, busy_dropped);
        n_tests++;
        if (cmd_log.size() != r_exp + s_exp) begin
            n_fail++;
            $display("FAIL %s cmd_count: got %0d want %0d", tag, cmd_log.size(), r_exp + s_exp);
        end
        for (int i = 0; i < cmd_log.size() && i < r_exp + s_exp; i++) begin
            logic [FW-1:0] efid = (i < r_exp) ? FW'(1) : FW'(2);
            logic [DW-1:0] ein0 = (i < r_exp) ? exp_rows[i] : '0;
            logic [DW-1:0] ein1 = (i < r_exp) ? DW'((ABASE + i) % 256) : '0;
            n_tests++;
            if (cmd_log[i].fid !== efid || cmd_log[i].in0 !== ein0 || cmd_log[i].in1 !== ein1) begin
                n_fail++;
                $display("FAIL %s cmd[%0d]: got fid=%0h in0=%0h in1=%0h want fid=%0h in0=%0h in1=%0h",
                         tag, i, cmd_log[i].fid, cmd_log[i].in0, cmd_log[i].in1, efid, ein0, ein1);
            end
        end
        want = (s_exp > 0) ? exp_macs[s_exp-1] : '0;
        n_tests++;
        if (got !== want) begin
            n_fail++; $display("FAIL %s res_data: got %0h want %0h", tag, got, want);
        end
        row_q.delete();
        mac_rsp_q.delete();
    endtask

    task automatic fill(input int nrows, input int nmacs);
        exp_rows.delete(); exp_macs.delete();
        for (int i = 0; i < nrows; i++) exp_rows.push_back($urandom);
        for (int i = 0; i < nmacs; i++) exp_macs.push_back($urandom);
    endtask

    task automatic test_reset;
        logic [7:0] got;
        logic [7:0] want;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        got  = {job_ready, row_ready, pim_cmd_valid, pim_rsp_ready, res_valid, busy,
                |pim_function_id, |{pim_inputs_0, pim_inputs_1, res_data}};
        want = 8'b1000_0000;
        n_tests++;
        if (got !== want) begin
            n_fail++; $display("FAIL reset_outputs: got %b want %b", got, want);
        end
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic;
        int cyc; bit bd;
        exp_rows = '{32'h0000_000F, 32'h0000_00F0};
        exp_macs = '{32'h1, 32'h5, 32'h9};
        run_job(2, 3, "basic", cyc, bd);
        n_tests++;
        if (cyc != 12) begin
            n_fail++; $display("FAIL basic_latency: got %0d cycles want 12", cyc);
        end
        n_tests++;
        if (bd) begin
            n_fail++; $display("FAIL basic_busy: busy dropped=1 want 0");
        end
    endtask

    task automatic test_zero_job;
        int cyc; bit bd;
        fill(0, 0);
        run_job(0, 0, "zero", cyc, bd);
        n_tests++;
        if (cyc != 0) begin
            n_fail++; $display("FAIL zero_latency: got %0d cycles want 0", cyc);
        end
    endtask

    task automatic test_cmd_stall;
        int cyc; bit bd;
        fill(1, 0);
        cmd_stall = 5; stall_cycles_seen = 0;
        run_job(1, 0, "stall", cyc, bd);
        cmd_stall = 0;
        n_tests++;
        if (stall_cycles_seen != 5) begin
            n_fail++; $display("FAIL stall_cycles: got %0d want 5", stall_cycles_seen);
        end
    endtask

    task automatic test_saturate;
        int cyc; bit bd;
        fill(256, 32);
        run_job(300, 40, "saturate", cyc, bd);
        n_tests++;
        if (bd) begin
            n_fail++; $display("FAIL saturate_busy: busy dropped=1 want 0");
        end
    endtask

    task automatic test_done_hold;
        int            k = 0;
        logic [DW-1:0] held_res;
        bit            bad = 0;
        fill(0, 2);
        cmd_log.delete();
        mac_rsp_q = exp_macs;
        send_job(0, 2);
        while (!res_valid && k < 200) begin @(negedge clk); k++; end
        held_res = res_data;
        n_tests++;
        if (res_valid !== 1'b1 || held_res !== exp_macs[1]) begin
            n_fail++; $display("FAIL hold_result: got v=%0b data=%0h want v=1 data=%0h", res_valid, held_res, exp_macs[1]);
        end
        for (int c = 0; c < 4; c++) begin
            job_valid = (c == 1 || c == 2); job_rows = 9'd3; job_steps = 6'd1;
            @(negedge clk);
            if (res_valid !== 1'b1 || res_data !== held_res || job_ready !== 1'b0) bad = 1;
        end
        job_valid = 1'b0;
        n_tests++;
        if (bad) begin
            n_fail++; $display("FAIL hold_stable: got v=%0b data=%0h job_ready=%0b want v=1 data=%0h job_ready=0",
                               res_valid, res_data, job_ready, held_res);
        end
        res_ready = 1'b1; @(negedge clk); res_ready = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if (job_ready !== 1'b1 || busy !== 1'b0 || cmd_log.size() != 2) begin
            n_fail++; $display("FAIL hold_release: got job_ready=%0b busy=%0b cmds=%0d want 1 0 2",
                               job_ready, busy, cmd_log.size());
        end
        mac_rsp_q.delete();
    endtask

    task automatic test_reset_mid;
        int         k = 0;
        logic [4:0] got;
        bit         bad = 0;
        fill(1, 3);
        rsp_delay = 3;
        cmd_log.delete();
        row_q = exp_rows; mac_rsp_q = exp_macs;
        send_job(1, 3);
        while (!(cmd_log.size() == 3 && pim_rsp_ready) && k < 200) begin @(negedge clk); k++; end
        n_tests++;
        if (!(cmd_log.size() == 3 && pim_rsp_ready)) begin
            n_fail++; $display("FAIL midrst_reach: cmds=%0d rsp_ready=%0b want 3 1", cmd_log.size(), pim_rsp_ready);
        end
        #2 reset = 1'b1;
        #1 got = {job_ready, pim_cmd_valid, pim_rsp_ready, res_valid, busy};
        n_tests++;
        if (got !== 5'b10000) begin
            n_fail++; $display("FAIL midrst_outputs: got %b want 10000", got);
        end
        @(posedge clk); #1 reset = 1'b0;
        row_q.delete(); mac_rsp_q.delete(); rsp_delay = 0;
        repeat (6) begin
            @(negedge clk);
            if (res_valid !== 1'b0 || job_ready !== 1'b1) bad = 1;
        end
        n_tests++;
        if (bad) begin
            n_fail++; $display("FAIL midrst_after: res_valid=%0b job_ready=%0b want 0 1", res_valid, job_ready);
        end
    endtask

    task automatic test_random;
        int cyc; bit bd;
        row_gaps = 1;
        for (int j = 0; j < 5; j++) begin
            int rows  = $urandom_range(0, 6);
            int steps = $urandom_range(0, 6);
            cmd_stall = $urandom_range(0, 2);
            rsp_delay = $urandom_range(0, 2);
            fill(rows, steps);
            run_job(rows, steps, "random", cyc, bd);
        end
        row_gaps = 0; cmd_stall = 0; rsp_delay = 0;
    endtask

    initial begin
        test_reset;
        test_basic;
        test_zero_job;
        test_cmd_stall;
        test_saturate;
        test_done_hold;
        test_reset_mid;
        test_random;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/pim_mac_seq.md
Name: pim_mac_seq

Overview:
Sequencer that fronts the PIM CFU array for one complete bit-serial MAC job. It accepts a job descriptor, streams weight rows into the array with write commands, then issues the configured number of MAC (shift-accumulate) commands. It returns the final MAC response to the requester. Sits between the CPU-side job/row streams and the PIM CFU cmd/rsp interface, with one command outstanding at a time.

Parameters:
DWIDTH, 32, data width of row words, PIM inputs and responses
FWIDTH, 10, width of PIM function_id
MAX_ROWS, 256, maximum rows per job (row address space is 8 bits)
ADDR_BASE, 0, row address of the first loaded row

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
job_valid  in  1  job descriptor valid
job_ready  out  1  sequencer can accept a job
job_rows  in  9  rows to load, 0..MAX_ROWS
job_steps  in  6  MAC steps to issue, 0..32
row_valid  in  1  row word valid
row_ready  out  1  row word accepted
row_data  in  DWIDTH  weight row word
pim_cmd_valid  out  1  command to PIM valid
pim_cmd_ready  in  1  PIM accepts command
pim_function_id  out  FWIDTH  01 = write, 10 = MAC, others zero
pim_inputs_0  out  DWIDTH  write data; zero for MAC
pim_inputs_1  out  DWIDTH  row address; zero for MAC
pim_rsp_valid  in  1  PIM response valid
pim_rsp_ready  out  1  sequencer accepts response
pim_rsp_data  in  DWIDTH  PIM response payload
res_valid  out  1  result valid
res_ready  in  1  requester accepts result
res_data  out  DWIDTH  final MAC result
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset is asynchronous and active-high. On reset, state = IDLE and all counters are zero. All outputs reset to 0 except job_ready, which is 1.
- Handshakes: a transfer occurs on a clk edge where valid && ready.
- The sequencer holds pim_cmd_valid, function_id, inputs_0 and inputs_1 stable until pim_cmd_ready is sampled high.
- pim_rsp_ready is high only in the WAIT states.
- States:
  - IDLE: job_ready=1. On job handshake, latch rows = min(job_rows, MAX_ROWS) and steps = min(job_steps, 32), and clear row_idx, step_idx and the result register. Next state: LOAD_GET if rows>0, else MAC_ISSUE if steps>0, else DONE.
  - LOAD_GET: row_ready=1. On row handshake, latch row_data, then go to LOAD_ISSUE.
  - LOAD_ISSUE: cmd_valid=1, function_id=01, inputs_0=latched row, inputs_1=ADDR_BASE+row_idx (lower 8 bits). On cmd handshake, go to LOAD_WAIT.
  - LOAD_WAIT: on rsp handshake, row_idx += 1. If row_idx+1 == rows, go to MAC_ISSUE (or DONE if steps==0); else go to LOAD_GET. Response data is discarded.
  - MAC_ISSUE: cmd_valid=1, function_id=10. On cmd handshake, go to MAC_WAIT.
  - MAC_WAIT: on rsp handshake, result = pim_rsp_data and step_idx += 1. If step_idx+1 == steps, go to DONE; else go to MAC_ISSUE.
  - DONE: res_valid=1, res_data=result (0 if steps==0). On res handshake, go to IDLE.
- Latency:
  - Each row costs at least 3 cycles: get, issue, wait with zero-wait PIM.
  - Each step costs at least 2 cycles.
  - Result is presented one cycle after the final response.
- Boundaries:
  - job_rows > MAX_ROWS saturates to MAX_ROWS. job_steps > 32 saturates to 32.
  - A pim_rsp_valid outside a WAIT state is ignored; rsp_ready is 0 there.
  - A pim_rsp_valid in the same cycle as the cmd handshake is not consumed. The response is accepted from the next cycle on.
  - job_valid while busy is not accepted (job_ready=0).
  - res_ready held low keeps the block in DONE indefinitely with res_data stable.
  - Reset mid-job aborts immediately to IDLE and drops cmd_valid that cycle. No partial result is emitted.

Test Plan:
- Job rows=2, steps=3; rows 0x0000000F, 0x000000F0; PIM ready/rsp in 1 cycle, MAC responses 0x1, 0x5, 0x9 -> writes addr 0/1 with the given data, three function_id=10 commands, then res_data=0x9 with res_valid=1.
- rows=0, steps=0 -> IDLE to DONE in one cycle; res_data=0; no pim_cmd_valid ever asserted.
- pim_cmd_ready held low 5 cycles during LOAD_ISSUE -> cmd_valid, inputs_0 and inputs_1 stable all 5 cycles; exactly one write issued.
- job_rows=300 -> exactly 256 write commands, addresses 0..255; busy remains 1 throughout.
- res_ready low for 4 cycles in DONE, plus job_valid pulsed meanwhile -> res_data stable, job not accepted, job_ready=0 until the res handshake.
- Reset asserted asynchronously during MAC_WAIT of step 2 -> outputs zero immediately, job_ready=1 after, no res_valid.
